// File: rtl/load_store_unit.sv
// load_store_unit: single-request load/store initiator for a word-addressed data memory.
// Accepts one byte-addressed LW/LH/LHU/LB/LBU/SW/SH/SB request at a time. It performs loads
// with sign/zero extension and sub-word stores as a read-modify-write. Misaligned or
// out-of-range requests return an error response without touching memory.
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   req_valid_i/ready_o   request handshake (ready only in idle)
//   req_op_i              000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
//   req_addr_i            byte address
//   req_wdata_i           store data
//   resp_valid_o          one-cycle completion pulse
//   resp_rdata_o          extended load result (0 for stores/errors)
//   resp_err_o            misaligned / out-of-range flag
//   mem_access_addr_o     word index
//   mem_write_data_o      word to write
//   mem_write_en_o        write strobe
//   mem_read_en_o         read enable
//   mem_read_data_i       combinational read data
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 251
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [31:0] mem_access_addr_o,
    output logic [31:0] mem_write_data_o,
    output logic        mem_write_en_o,
    output logic        mem_read_en_o,
    input  logic [31:0] mem_read_data_i
);

    localparam logic [2:0] OpLw  = 3'b000;
    localparam logic [2:0] OpLh  = 3'b001;
    localparam logic [2:0] OpLhu = 3'b010;
    localparam logic [2:0] OpLb  = 3'b011;
    localparam logic [2:0] OpLbu = 3'b100;
    localparam logic [2:0] OpSw  = 3'b101;
    localparam logic [2:0] OpSh  = 3'b110;
    localparam logic [2:0] OpSb  = 3'b111;

    typedef enum logic [2:0] {StIdle, StLoad, StRmwRead, StWrite, StResp} state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [29:0] idx_q, idx_d;
    logic [1:0]  lane_q, lane_d;
    // Holds the store data on acceptance, then the merged word after the RMW read.
    logic [31:0] merged_q, merged_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        misaligned, out_of_range, is_store;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val, merge_val;

    always_comb begin
        misaligned = 1'b0;
        unique case (req_op_i)
            OpLw, OpSw:        misaligned = (req_addr_i[1:0] != 2'b00);
            OpLh, OpLhu, OpSh: misaligned = req_addr_i[0];
            default:           misaligned = 1'b0;
        endcase
    end

    assign out_of_range = ({2'b00, req_addr_i[31:2]} >= MEM_WORDS);
    assign is_store     = req_op_i[2] & (req_op_i[1] | req_op_i[0]);

    // Little-endian lane extraction from the read word.
    always_comb begin
        rd_byte = 8'h00;
        unique case (lane_q)
            2'd0: rd_byte = mem_read_data_i[7:0];
            2'd1: rd_byte = mem_read_data_i[15:8];
            2'd2: rd_byte = mem_read_data_i[23:16];
            2'd3: rd_byte = mem_read_data_i[31:24];
            default: rd_byte = 8'h00;
        endcase
    end

    assign rd_half = lane_q[1] ? mem_read_data_i[31:16] : mem_read_data_i[15:0];

    always_comb begin
        load_val = mem_read_data_i;
        unique case (op_q)
            OpLh:    load_val = {{16{rd_half[15]}}, rd_half};
            OpLhu:   load_val = {16'h0000, rd_half};
            OpLb:    load_val = {{24{rd_byte[7]}}, rd_byte};
            OpLbu:   load_val = {24'h000000, rd_byte};
            default: load_val = mem_read_data_i;
        endcase
    end

    always_comb begin
        merge_val = mem_read_data_i;
        unique case (op_q)
            OpSb: merge_val = (mem_read_data_i & ~(32'h0000_00FF << {lane_q, 3'b000}))
                              | ({24'h000000, merged_q[7:0]} << {lane_q, 3'b000});
            OpSh: merge_val = lane_q[1] ? {merged_q[15:0], mem_read_data_i[15:0]}
                                        : {mem_read_data_i[31:16], merged_q[15:0]};
            default: merge_val = mem_read_data_i;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        idx_d    = idx_q;
        lane_d   = lane_q;
        merged_d = merged_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    op_d     = req_op_i;
                    idx_d    = req_addr_i[31:2];
                    lane_d   = req_addr_i[1:0];
                    merged_d = req_wdata_i;
                    if (misaligned || out_of_range) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else if (is_store) begin
                        state_d = (req_op_i == OpSw) ? StWrite : StRmwRead;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                rdata_d = load_val;
                err_d   = 1'b0;
                state_d = StResp;
            end
            StRmwRead: begin
                merged_d = merge_val;
                state_d  = StWrite;
            end
            StWrite: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            op_q     <= 3'b000;
            idx_q    <= 30'h0;
            lane_q   <= 2'b00;
            merged_q <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            lane_q   <= lane_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Moore outputs decoded from state only, so reset drops the enables immediately.
    assign req_ready_o       = (state_q == StIdle);
    assign resp_valid_o      = (state_q == StResp);
    assign resp_rdata_o      = rdata_q;
    assign resp_err_o        = err_q;
    assign mem_read_en_o     = (state_q == StLoad) || (state_q == StRmwRead);
    assign mem_write_en_o    = (state_q == StWrite);
    assign mem_write_data_o  = (state_q == StWrite) ? merged_q : 32'h0;
    assign mem_access_addr_o = (mem_read_en_o || mem_write_en_o) ? {2'b00, idx_q} : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a simple word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_access_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_read_data;

    logic [31:0] mem [256];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(251)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_op_i          (req_op),
        .req_addr_i        (req_addr),
        .req_wdata_i       (req_wdata),
        .resp_valid_o      (resp_valid),
        .resp_rdata_o      (resp_rdata),
        .resp_err_o        (resp_err),
        .mem_access_addr_o (mem_access_addr),
        .mem_write_data_o  (mem_write_data),
        .mem_write_en_o    (mem_write_en),
        .mem_read_en_o     (mem_read_en),
        .mem_read_data_i   (mem_read_data)
    );

    assign mem_read_data = mem[mem_access_addr[7:0]];

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_access_addr[7:0]] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; report response, latency (edges after acceptance before the
    // resp_valid cycle), enable-cycle counts and the last write seen.
    task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat, output int nrd,
                          output int nwr, output logic [31:0] waddr, output logic [31:0] wdat);
        logic got;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; got = 1'b0;
        rdata = 32'hx; err = 1'bx; waddr = 32'hx; wdat = 32'hx;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (mem_read_en) nrd++;
            if (mem_write_en) begin
                nwr++;
                waddr = mem_access_addr;
                wdat  = mem_write_data;
            end
            if (resp_valid) begin
                got   = 1'b1;
                rdata = resp_rdata;
                err   = resp_err;
            end else begin
                lat++;
            end
        end
        check("resp_seen", {31'b0, got}, 32'd1);
        @(negedge clk);
        check("resp_one_cycle", {31'b0, resp_valid}, 32'd0);
        check("ready_after", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic load_chk(input string tag, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] exp);
        logic [31:0] rd, wa, wd;
        logic e;
        int lat, nrd, nwr;
        do_req(op, addr, 32'h0, rd, e, lat, nrd, nwr, wa, wd);
        check({tag, "_data"}, rd, exp);
        check({tag, "_err"}, {31'b0, e}, 32'd0);
        check({tag, "_lat"}, lat, 32'd1);
        check({tag, "_nrd"}, nrd, 32'd1);
        check({tag, "_nwr"}, nwr, 32'd0);
    endtask

    task automatic store_chk(input string tag, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] exp_word,
                             input int exp_lat, input int exp_nrd);
        logic [31:0] rd, wa, wd;
        logic e;
        int lat, nrd, nwr;
        do_req(op, addr, wdata, rd, e, lat, nrd, nwr, wa, wd);
        check({tag, "_wdata"}, wd, exp_word);
        check({tag, "_waddr"}, wa, {2'b00, addr[31:2]});
        check({tag, "_nwr"}, nwr, 32'd1);
        check({tag, "_nrd"}, nrd, exp_nrd);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_err"}, {31'b0, e}, 32'd0);
        check({tag, "_rdata"}, rd, 32'd0);
    endtask

    task automatic err_chk(input string tag, input logic [2:0] op, input logic [31:0] addr);
        logic [31:0] rd, wa, wd;
        logic e;
        int lat, nrd, nwr;
        do_req(op, addr, 32'hFFFF_FFFF, rd, e, lat, nrd, nwr, wa, wd);
        check({tag, "_err"}, {31'b0, e}, 32'd1);
        check({tag, "_rdata"}, rd, 32'd0);
        check({tag, "_lat"}, lat, 32'd0);
        check({tag, "_nrd"}, nrd, 32'd0);
        check({tag, "_nwr"}, nwr, 32'd0);
    endtask

    initial begin
        int pulses;
        int waited;
        logic [31:0] rd, wa, wd;
        logic e;
        int lat, nrd, nwr;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'b0, resp_err}, 32'd0);
        check("rst_addr", mem_access_addr, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        check("rst_en", {30'b0, mem_write_en, mem_read_en}, 32'd0);
        reset = 1'b0;

        store_chk("sw10", 3'b101, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0);
        load_chk("lw10", 3'b000, 32'h10, 32'hDEAD_BEEF);
        load_chk("lb13", 3'b011, 32'h13, 32'hFFFF_FFDE);
        load_chk("lbu13", 3'b100, 32'h13, 32'h0000_00DE);
        load_chk("lh12", 3'b001, 32'h12, 32'hFFFF_DEAD);
        load_chk("lhu10", 3'b010, 32'h10, 32'h0000_BEEF);
        load_chk("lb10", 3'b011, 32'h10, 32'hFFFF_FFEF);

        store_chk("sb11", 3'b111, 32'h11, 32'h0000_00AA, 32'hDEAD_AAEF, 2, 1);
        store_chk("sh12", 3'b110, 32'h12, 32'h0000_1234, 32'h1234_AAEF, 2, 1);
        load_chk("lw10b", 3'b000, 32'h10, 32'h1234_AAEF);
        load_chk("lh10", 3'b001, 32'h10, 32'hFFFF_AAEF);

        err_chk("lw12", 3'b000, 32'h12);
        err_chk("sh11", 3'b110, 32'h11);
        err_chk("lw3ec", 3'b000, 32'h3EC);
        load_chk("lw3e8", 3'b000, 32'h3E8, 32'h0);

        // Reset during the WRITE cycle of an SB must abort without writing.
        store_chk("sw20", 3'b101, 32'h20, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'b111;
        req_addr  = 32'h20;
        req_wdata = 32'h0000_0055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        pulses = 0;
        waited = 0;
        while (!mem_write_en && waited < 6) begin
            @(negedge clk);
            if (resp_valid) pulses++;
            waited++;
        end
        check("rst_reached_write", {31'b0, mem_write_en}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_we_drop", {31'b0, mem_write_en}, 32'd0);
        check("rst_addr_drop", mem_access_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check("rst_no_resp", pulses, 32'd0);
        check("rst_ready_after", {31'b0, req_ready}, 32'd1);
        check("rst_word8", mem[8], 32'hCAFE_F00D);
        do_req(3'b000, 32'h20, 32'h0, rd, e, lat, nrd, nwr, wa, wd);
        check("rst_lw20", rd, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for the word-addressed data memory. It accepts one byte-addressed load or store request at a time from the MEM stage and performs the access on the memory's single shared-address port. It handles LW/LH/LHU/LB/LBU/SW/SH/SB, including sign/zero extension for loads and read-modify-write for sub-word stores. Misaligned and out-of-range requests complete with an error response and never touch memory.

## Interface
- MEM_WORDS, 251: number of valid memory words; legal word index range is 0..MEM_WORDS-1.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all registers.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on a rising edge where req_valid && req_ready.
- req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; SH uses [15:0], SB uses [7:0].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; 1 = misaligned or out of range.
- mem_access_addr  out  32  word index = {2'b00, addr[31:2]}.
- mem_write_data  out  32  word to write.
- mem_write_en  out  1  memory writes on the rising edge while high.
- mem_read_en  out  1  enables the memory's combinational read.
- mem_read_data  in  32  read word, valid in the same cycle as mem_read_en.

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, RESP. Moore outputs; enables decode from state only.
- IDLE: req_ready=1; on acceptance, latch op, word index, lane addr[1:0], wdata.
  - Misaligned (LW/SW: addr[1:0]!=0; LH/LHU/SH: addr[0]!=0) or word index >= MEM_WORDS -> RESP with err=1.
  - Loads -> LOAD. SW -> WRITE with merged word = wdata. SH/SB -> RMW_READ.
- LOAD: mem_read_en=1. On the edge, extract and extend mem_read_data into the result register -> RESP.
- RMW_READ: mem_read_en=1. On the edge, capture mem_read_data with the addressed lanes replaced by wdata -> WRITE.
- WRITE: mem_write_en=1, mem_write_data=merged word -> RESP.
- RESP: resp_valid=1 for one cycle -> IDLE. No request is accepted in RESP.
- Lanes are little-endian: byte n = bits [8n+7:8n] at addr[1:0]=n; halfword at addr[1]=0 is [15:0], at addr[1]=1 is [31:16].
- LB/LH sign-extend; LBU/LHU zero-extend.
- mem_access_addr is driven from the latched index in LOAD/RMW_READ/WRITE and is 0 otherwise. mem_write_data is 0 outside WRITE.
- resp_rdata and resp_err hold their values until the next RESP.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_access_addr=0, mem_write_data=0, mem_write_en=0, mem_read_en=0.
- Counting from the acceptance edge (T0), resp_valid is high in the cycle after:
  - T2 for loads and SW;
  - T3 for SH/SB;
  - T1 for errors.
- Exactly one mem_write_en cycle per legal store; zero for loads and errors.
- At most one mem_read_en cycle per request.
- Back-to-back requests: the next acceptance is at the earliest on the edge ending RESP+1 (i.e., the first IDLE cycle).
- Reset mid-operation: state goes to IDLE immediately and enables drop combinationally. A store interrupted in WRITE before its edge writes nothing. No resp_valid is issued for the aborted request.
- req_valid while not ready is ignored; the requester holds the request.

## Test plan
- SW 0x10 data 0xDEADBEEF -> one mem_write_en cycle, mem_access_addr=4, data 0xDEADBEEF; resp_valid at T2, err=0. Then LW 0x10 -> resp_rdata=0xDEADBEEF.
- After that store: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x11 data 0xAA -> read cycle then write cycle of 0xDEADAAEF, resp at T3. Then SH 0x12 data 0x1234 -> word 0x1234AAEF (check with LW).
- LW 0x12 and SH 0x11 -> resp_err=1 at T1, resp_rdata=0, no mem_read_en or mem_write_en ever high.
- LW 0x3EC (word 251) -> resp_err=1. LW 0x3E8 (word 250) -> err=0.
- SB 0x20 with reset asserted during WRITE -> mem_write_en falls immediately, word at index 8 unchanged, no resp_valid, req_ready=1 after reset release.
